// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment capture block.
//   - Lit-segment patterns {a,b,c,d,e,f,g} (bit 6 = a) for digits 0..9.
//   - Digit slot indices as carried on the digit enables.
//   - Frame-assembly state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam int unsigned SEC_ONES = 0;
  localparam int unsigned SEC_TENS = 1;
  localparam int unsigned MIN_ONES = 2;
  localparam int unsigned MIN_TENS = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXPECT1,
    EXPECT2,
    EXPECT3
  } frame_state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-segment to BCD decoder.
//   i_seg   : lit pattern {a..g}, 1 = segment lit
//   o_bcd   : decoded digit (0 when undecodable)
//   o_valid : 1 when i_seg is one of the ten digit patterns
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_valid
);

  always_comb begin
    o_bcd   = '0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed 4-digit MM:SS 7-segment display,
// de-glitches it and publishes a coherent time once slots 0..3 were
// captured in order.
//   clk, rst_n        : clock, async active-low reset
//   seven_seg, digit_en : raw display lines (async to clk, polarity per CC)
//   err_clr           : synchronous clear of sticky error flags
//   sec_ones..min_tens: published BCD time
//   frame_valid       : one-cycle pulse on publish
//   digit_valid       : slots captured in the current frame
//   seg_err, en_err   : sticky undecodable-pattern / multi-enable flags
//   range_err         : sticky out-of-range publish flag; built only when
//                       SEG7_CAPTURE_RANGE_CHECK_EN is defined, else 0
module seg7_capture
  import seg7_pkg::*;
#(
  parameter bit          CC            = 1'b1,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seven_seg,
  input  logic [3:0] digit_en,
  input  logic       err_clr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       frame_valid,
  output logic [3:0] digit_valid,
  output logic       seg_err,
  output logic       en_err,
  output logic       range_err
);

  localparam logic [6:0] SEG_INACTIVE = CC ? 7'h00 : 7'h7F;
  localparam logic [3:0] EN_INACTIVE  = CC ? 4'hF : 4'h0;
  localparam logic [7:0] CAP_COUNT    = 8'(STABLE_CYCLES - 1);

  logic [6:0]       r_seg_s1, r_seg_s2, r_prev_seg, w_seg_lit;
  logic [3:0]       r_en_s1, r_en_s2, r_prev_en, w_en_act;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [1:0]       w_slot;
  logic [3:0]       w_bcd, w_dv_nxt;
  logic [2:0][3:0]  r_shadow;
  logic             w_dec_ok, w_capture, w_multi, w_in_order, w_publish;
  frame_state_t     r_state, w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= SEG_INACTIVE;
      r_seg_s2 <= SEG_INACTIVE;
      r_en_s1  <= EN_INACTIVE;
      r_en_s2  <= EN_INACTIVE;
    end else begin
      r_seg_s1 <= seven_seg;
      r_seg_s2 <= r_seg_s1;
      r_en_s1  <= digit_en;
      r_en_s2  <= r_en_s1;
    end
  end

  assign w_seg_lit = CC ? r_seg_s2 : ~r_seg_s2;
  assign w_en_act  = CC ? ~r_en_s2 : r_en_s2;
  assign w_multi   = !$onehot0(w_en_act);

  // Count is the number of repeats of the current sample; the capture fires
  // only when it passes exactly CAP_COUNT, so a long dwell captures once.
  always_comb begin
    if ({w_en_act, w_seg_lit} != {r_prev_en, r_prev_seg}) w_cnt_nxt = '0;
    else if (r_cnt == 8'hFF)                                w_cnt_nxt = r_cnt;
    else                                                    w_cnt_nxt = r_cnt + 8'd1;
  end

  assign w_capture = $onehot(w_en_act) && (w_cnt_nxt == CAP_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_seg <= '0;
      r_prev_en  <= '0;
      r_cnt      <= '0;
    end else begin
      r_prev_seg <= w_seg_lit;
      r_prev_en  <= w_en_act;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_slot = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (w_en_act[i]) w_slot = 2'(i);
  end

  seg7_decode u_decode (
    .i_seg   (w_seg_lit),
    .o_bcd   (w_bcd),
    .o_valid (w_dec_ok)
  );

  assign w_in_order = ((r_state == EXPECT1) && (w_slot == 2'(SEC_TENS))) ||
                      ((r_state == EXPECT2) && (w_slot == 2'(MIN_ONES))) ||
                      ((r_state == EXPECT3) && (w_slot == 2'(MIN_TENS)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_capture) begin
      if (!w_dec_ok)                        w_state_nxt = IDLE;
      else if (w_slot == 2'(SEC_ONES))      w_state_nxt = EXPECT1;
      else if (!w_in_order)                 w_state_nxt = IDLE;
      else begin
        case (r_state)
          EXPECT1: w_state_nxt = EXPECT2;
          EXPECT2: w_state_nxt = EXPECT3;
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_publish = w_capture && w_dec_ok && (r_state == EXPECT3) &&
                (w_slot == 2'(MIN_TENS));
    w_dv_nxt  = digit_valid;
    if (w_capture) begin
      if (!w_dec_ok)                   w_dv_nxt = '0;
      else if (w_slot == 2'(SEC_ONES)) w_dv_nxt = 4'b0001;
      else if (w_in_order)             w_dv_nxt = digit_valid | (4'b0001 << w_slot);
      else                             w_dv_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      sec_ones    <= '0;
      sec_tens    <= '0;
      min_ones    <= '0;
      min_tens    <= '0;
      frame_valid <= 1'b0;
      digit_valid <= '0;
      seg_err     <= 1'b0;
      en_err      <= 1'b0;
    end else begin
      frame_valid <= w_publish;
      digit_valid <= w_dv_nxt;
      if (w_capture && w_dec_ok && (w_slot != 2'(MIN_TENS)))
        r_shadow[w_slot] <= w_bcd;
      if (w_publish) begin
        sec_ones <= r_shadow[SEC_ONES];
        sec_tens <= r_shadow[SEC_TENS];
        min_ones <= r_shadow[MIN_ONES];
        min_tens <= w_bcd;
      end
      if (w_capture && !w_dec_ok) seg_err <= 1'b1;
      else if (err_clr)           seg_err <= 1'b0;
      if (w_multi)                en_err  <= 1'b1;
      else if (err_clr)           en_err  <= 1'b0;
    end
  end

`ifdef SEG7_CAPTURE_RANGE_CHECK_EN
  logic w_range_bad;
  assign w_range_bad = w_publish && ((w_bcd > 4'd5) ||
                                     (r_shadow[MIN_ONES] > 4'd9) ||
                                     (r_shadow[SEC_TENS] > 4'd5) ||
                                     (r_shadow[SEC_ONES] > 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           range_err <= 1'b0;
    else if (w_range_bad) range_err <= 1'b1;
    else if (err_clr)     range_err <= 1'b0;
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: two instances (CC=1/STABLE=4 and CC=0/STABLE=1)
// see the same logical display, driven with opposite raw polarity.
module tb_seg7_capture;

  localparam int ST_A = 4;
  localparam int ST_B = 1;

  localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                      7'b1111001, 7'b0110011, 7'b1011011,
                                      7'b1011111, 7'b1110000, 7'b1111111,
                                      7'b1111011};

`ifdef SEG7_CAPTURE_RANGE_CHECK_EN
  localparam logic RANGE_ON = 1'b1;
`else
  localparam logic RANGE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [6:0] lit = '0;
  logic [3:0] act = '0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] en_a, en_b;

  assign seg_a = lit;
  assign en_a  = ~act;
  assign seg_b = ~lit;
  assign en_b  = act;

  logic [3:0] o_so [2];
  logic [3:0] o_st [2];
  logic [3:0] o_mo [2];
  logic [3:0] o_mt [2];
  logic [3:0] o_dv [2];
  logic       o_fv [2];
  logic       o_se [2];
  logic       o_ee [2];
  logic       o_re [2];

  int n_checks = 0;
  int n_err = 0;
  int fv_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  seg7_capture #(.CC(1'b1), .STABLE_CYCLES(ST_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seven_seg(seg_a), .digit_en(en_a), .err_clr(err_clr),
    .sec_ones(o_so[0]), .sec_tens(o_st[0]), .min_ones(o_mo[0]), .min_tens(o_mt[0]),
    .frame_valid(o_fv[0]), .digit_valid(o_dv[0]), .seg_err(o_se[0]),
    .en_err(o_ee[0]), .range_err(o_re[0]));

  seg7_capture #(.CC(1'b0), .STABLE_CYCLES(ST_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seven_seg(seg_b), .digit_en(en_b), .err_clr(err_clr),
    .sec_ones(o_so[1]), .sec_tens(o_st[1]), .min_ones(o_mo[1]), .min_tens(o_mt[1]),
    .frame_valid(o_fv[1]), .digit_valid(o_dv[1]), .seg_err(o_se[1]),
    .en_err(o_ee[1]), .range_err(o_re[1]));

  // Reference: d1/d2 carry the logical {active enables, lit segments} through
  // the two sampling stages; run = how many identical samples in a row.
  typedef struct packed {
    logic [10:0]      d1, d2, prev;
    int               run;
    int               expct;
    logic [3:0][3:0]  sh;
    logic [3:0][3:0]  pub;
    logic [3:0]       dv;
    logic             fv, serr, eerr, rerr;
  } model_t;

  model_t mdl [2];

  function automatic model_t model_reset();
    model_t m = '0;
    m.run   = 1;
    m.expct = -1;
    return m;
  endfunction

  function automatic model_t step(model_t m, logic [10:0] in, logic clr, int stable);
    model_t     n = m;
    logic [3:0] en = m.d2[10:7];
    logic [6:0] sg = m.d2[6:0];
    int         slot = 0;
    int         val = -1;
    if (m.d2 == m.prev) n.run = (m.run < 256) ? m.run + 1 : 256;
    else                n.run = 1;
    n.prev = m.d2;
    n.d2   = m.d1;
    n.d1   = in;
    n.fv   = 1'b0;
    if (clr) begin
      n.serr = 1'b0;
      n.eerr = 1'b0;
      n.rerr = 1'b0;
    end
    if ($countones(en) >= 2) n.eerr = 1'b1;
    if ($countones(en) == 1 && n.run == stable) begin
      for (int k = 0; k < 4; k++) if (en[k]) slot = k;
      for (int v = 0; v < 10; v++) if (PAT[v] == sg) val = v;
      if (val < 0) begin
        n.serr  = 1'b1;
        n.expct = -1;
        n.dv    = '0;
      end else if (slot == 0) begin
        n.sh[0] = 4'(val);
        n.dv    = 4'b0001;
        n.expct = 1;
      end else if (slot == m.expct) begin
        n.sh[slot] = 4'(val);
        n.dv[slot] = 1'b1;
        if (slot == 3) begin
          n.pub   = n.sh;
          n.fv    = 1'b1;
          n.expct = -1;
          if (RANGE_ON && (n.pub[3] > 5 || n.pub[1] > 5 || n.pub[2] > 9 || n.pub[0] > 9))
            n.rerr = 1'b1;
        end else begin
          n.expct = slot + 1;
        end
      end else begin
        n.expct = -1;
        n.dv    = '0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= model_reset();
      mdl[1] <= model_reset();
    end else begin
      mdl[0] <= step(mdl[0], {act, lit}, err_clr, ST_A);
      mdl[1] <= step(mdl[1], {act, lit}, err_clr, ST_B);
    end
  end

  function automatic logic [23:0] got_vec(int i);
    return {o_mt[i], o_mo[i], o_st[i], o_so[i], o_fv[i], o_dv[i], o_se[i], o_ee[i], o_re[i]};
  endfunction

  function automatic logic [23:0] exp_vec(model_t m);
    return {m.pub[3], m.pub[2], m.pub[1], m.pub[0], m.fv, m.dv, m.serr, m.eerr, m.rerr};
  endfunction

  function automatic logic [15:0] tm(int i);
    return {o_mt[i], o_mo[i], o_st[i], o_so[i]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_vec(i) !== exp_vec(mdl[i])) begin
        n_err++;
        $display("FAIL outputs dut%0d t=%0t got=%h exp=%h", i, $time, got_vec(i), exp_vec(mdl[i]));
      end
      if (o_fv[i] === 1'b1) fv_cnt[i]++;
    end
  end

  task automatic chk(string name, logic [23:0] got, logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(logic [3:0] a, logic [6:0] l, int cyc);
    act = a;
    lit = l;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(int mt, int mo, int st, int so, int dwell);
    drive(4'b0001, PAT[so], dwell);
    drive(4'b0010, PAT[st], dwell);
    drive(4'b0100, PAT[mo], dwell);
    drive(4'b1000, PAT[mt], dwell);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", got_vec(0), 24'h0);
    chk("reset_b", got_vec(1), 24'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0000, 7'h00, 4);

    // normal scan 12:34, twice
    base = fv_cnt[0];
    scan(1, 2, 3, 4, 20);
    scan(1, 2, 3, 4, 20);
    drive(4'b0000, 7'h00, 8);
    @(negedge clk);
    chk("scan_time_a", 24'(tm(0)), 24'h1234);
    chk("scan_time_b", 24'(tm(1)), 24'h1234);
    chk("scan_frames_a", 24'(fv_cnt[0] - base), 24'd2);
    chk("scan_errs_a", {21'h0, o_se[0], o_ee[0], o_re[0]}, 24'h0);
    #1;

    // glitch: slot 2 too short
    base = fv_cnt[0];
    drive(4'b0001, PAT[5], 10);
    drive(4'b0010, PAT[6], 10);
    drive(4'b0100, PAT[7], 3);
    drive(4'b0000, 7'h00, 10);
    @(negedge clk);
    chk("glitch_dv_a", 24'(o_dv[0]), 24'h3);
    chk("glitch_frames_a", 24'(fv_cnt[0] - base), 24'd0);
    #1;

    // undecodable segment pattern on slot 1
    drive(4'b0001, PAT[0], 10);
    drive(4'b0010, 7'b0000001, 10);
    drive(4'b0000, 7'h00, 6);
    @(negedge clk);
    chk("segerr_set_a", 24'(o_se[0]), 24'h1);
    chk("segerr_dv_a", 24'(o_dv[0]), 24'h0);
    #1;
    pulse_clr();
    @(negedge clk);
    chk("segerr_clr_a", 24'(o_se[0]), 24'h0);
    #1;

    // two enables active for one cycle
    drive(4'b0011, PAT[8], 1);
    drive(4'b0000, 7'h00, 6);
    @(negedge clk);
    chk("enerr_a", 24'(o_ee[0]), 24'h1);
    chk("enerr_b", 24'(o_ee[1]), 24'h1);
    chk("enerr_dv_a", 24'(o_dv[0]), 24'h0);
    #1;
    pulse_clr();

    // out-of-order then clean scan
    base = fv_cnt[0];
    drive(4'b0001, PAT[9], 10);
    drive(4'b0100, PAT[1], 10);
    drive(4'b0010, PAT[2], 10);
    drive(4'b1000, PAT[3], 10);
    drive(4'b0000, 7'h00, 6);
    @(negedge clk);
    chk("ooo_frames_a", 24'(fv_cnt[0] - base), 24'd0);
    chk("ooo_hold_a", 24'(tm(0)), 24'h1234);
    #1;
    scan(5, 9, 5, 9, 12);
    drive(4'b0000, 7'h00, 8);
    @(negedge clk);
    chk("clean_time_a", 24'(tm(0)), 24'h5959);
    chk("clean_frames_a", 24'(fv_cnt[0] - base), 24'd1);
    #1;

    // 75:00 range check
    scan(7, 5, 0, 0, 12);
    drive(4'b0000, 7'h00, 8);
    @(negedge clk);
    chk("range_time_b", 24'(tm(1)), 24'h7500);
    chk("range_err_b", 24'(o_re[1]), 24'(RANGE_ON));
    chk("range_err_a", 24'(o_re[0]), 24'(RANGE_ON));
    #1;

    // reset while in EXPECT2
    drive(4'b0001, PAT[4], 10);
    drive(4'b0010, PAT[4], 10);
    drive(4'b0100, PAT[4], 2);
    #2;
    rst_n = 1'b0;
    act = '0;
    lit = '0;
    @(negedge clk);
    chk("midreset_a", got_vec(0), 24'h0);
    chk("midreset_b", got_vec(1), 24'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = fv_cnt[0];
    drive(4'b0000, 7'h00, 4);
    scan(4, 4, 4, 4, 12);
    drive(4'b0000, 7'h00, 8);
    @(negedge clk);
    chk("post_reset_time_a", 24'(tm(0)), 24'h4444);
    chk("post_reset_frames_a", 24'(fv_cnt[0] - base), 24'd1);
    #1;

    // randomized traffic, checked cycle by cycle against the model
    for (int r = 0; r < 250; r++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 4) begin
        scan($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 9), $urandom_range(1, 8));
      end else begin
        logic [3:0] a;
        logic [6:0] l;
        a = (kind == 4) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
        l = (kind == 5) ? 7'($urandom) : PAT[$urandom_range(0, 9)];
        err_clr = ($urandom_range(0, 7) == 0);
        drive(a, l, $urandom_range(1, 10));
        err_clr = 1'b0;
      end
    end
    drive(4'b0000, 7'h00, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the multiplexed 4-digit minutes/seconds 7-segment driver. Samples the 7 segment lines and 4 digit enables, synchronizes and de-glitches them, decodes each segment pattern back to BCD, and publishes a coherent MM:SS value once a complete digit-0..3 scan has been observed. Used on-chip as a loopback checker for the display driver, or to read an external multiplexed display.

## Interface
- `CC`, default 1: display polarity.
  - 1: segments active-high, `digit_en` active-low.
  - 0: segments active-low, `digit_en` active-high.
- `STABLE_CYCLES`, default 4, legal range 1..255: consecutive identical synchronized samples required before a digit is captured.
- `clk` input, 1 bit: single system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `seven_seg` input, 7 bits: segment lines {a,b,c,d,e,f,g}, bit 6 = a. Asynchronous to `clk`.
- `digit_en` input, 4 bits: digit enables. Bit 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
- `err_clr` input, 1 bit: synchronous clear of the sticky error flags.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens` output, 4 bits each: published BCD time.
- `frame_valid` output, 1 bit: one-cycle pulse when the published time updates.
- `digit_valid` output, 4 bits: slot n captured in the current frame.
- `seg_err` output, 1 bit: sticky; a stable, undecodable segment pattern was seen.
- `en_err` output, 1 bit: sticky; more than one enable was active.
- `range_err` output, 1 bit: sticky. Present only with the macro described under Configuration. Tied to 0 otherwise.

## Operation
- **Synchronizer:** 2-flop synchronizer on all 11 inputs.
- **Normalization:** invert the synchronized values as needed so that a segment is 1 = lit and an enable is 1 = active, regardless of `CC`.
- **Decode, active-high lit, a..g:**
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
  - Any other pattern is undecodable.
- **Stability counter:** 8-bit, saturating.
  - Cleared whenever the (enable, pattern) pair differs from the previous sample.
  - Otherwise increments.
  - A capture fires on the sample where the count reaches `STABLE_CYCLES`-1.
  - Captures at most once per dwell.
  - No capture while the enables are all-zero or multi-hot.
- **Capture of slot n:**
  - Decodable pattern: load the shadow digit n and set `digit_valid[n]`.
  - Undecodable pattern: set `seg_err` and abort the frame.
- **Frame FSM:**
  - States: IDLE, EXPECT1, EXPECT2, EXPECT3.
  - Capture of slot 0 from any state: clear `digit_valid` to 0001, go to EXPECT1.
  - Capture of slot k in state EXPECTk: advance to the next state.
  - Any other capture: go to IDLE and clear `digit_valid`.
  - Slot 3 captured in EXPECT3: load all four outputs (three shadow digits plus the new digit 3) in the same edge, pulse `frame_valid`, return to IDLE.
- **`en_err`:** set on any cycle where the normalized enable has two or more bits set.
- **`err_clr`:** clears all sticky flags. If a set condition occurs in the same cycle, the set wins.

## Timing
- **Reset values:**
  - All time outputs 0.
  - `digit_valid` 0, `frame_valid` 0, all error flags 0.
  - FSM in IDLE, counter 0.
  - Synchronizer flops hold the inactive level for the current `CC`.
- **Latency:** an input change becomes a capture after 2 + `STABLE_CYCLES` clocks. The digit register updates on that edge.
- **`frame_valid`:** high for exactly one cycle, on the same edge that the outputs update. Outputs hold their value between frames.
- **Minimum dwell:** each digit must be enabled for at least `STABLE_CYCLES` cycles. Shorter dwells are ignored silently.
- **Reset asserted mid-frame:** everything clears asynchronously. The next publish requires a fresh 0..3 sequence.
- **Same value re-scanned:** the frame still pulses `frame_valid`, with outputs unchanged.

## Configuration
- Macro `SEG7_CAPTURE_RANGE_CHECK_EN`.
- **Defined:**
  - At publish, `min_tens` > 5, `sec_tens` > 5, or any ones digit > 9 sets sticky `range_err`.
  - The out-of-range value is still published.
- **Undefined:**
  - No check logic is built.
  - `range_err` is constant 0.

## Structure
- **Package `seg7_pkg`:**
  - The ten segment-pattern constants.
  - The digit-index localparams: SEC_ONES = 0, SEC_TENS = 1, MIN_ONES = 2, MIN_TENS = 3.
  - The frame-state enum.
- **Sub-module `seg7_decode`:** combinational; 7-bit lit pattern in, 4-bit BCD plus a valid bit out.

## Test plan
- **Normal scan:** `CC`=1, `STABLE_CYCLES`=4, scan 20 cycles per digit showing 12:34 (enables 1110, 1101, 1011, 0111) -> one `frame_valid` per scan, outputs 1/2/3/4, no errors.
- **Glitch rejection:** slot 2 pattern held 3 cycles -> no capture, `digit_valid` stays 0011, no publish.
- **Undecodable pattern:** stable lit pattern 0000001 on slot 1 -> `seg_err`=1, FSM to IDLE. `err_clr` pulse -> `seg_err`=0.
- **Enable errors:** enables 1100 active-low (two active) for 1 cycle -> `en_err`=1, no capture.
- **Out-of-order scan:** slot order 0, 2, 1, 3 -> no `frame_valid`. Next clean 0..3 scan -> publish.
- **Range check and reset:**
  - `CC`=0 with 75:00 scanned -> `range_err`=1 with the macro, 0 without.
  - `rst_n` low during EXPECT2 -> all outputs 0, then a clean frame publishes.
